// File: rtl/exmem_skid_if.sv
// EX->MEM stage bus: upstream entry fields with valid/ready, downstream
// presented entry with valid/ready, and the current fill level.
interface exmem_skid_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_wb;
  logic [2:0]        in_m;
  logic              in_zero;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] in_btarget;
  logic [REG_W-1:0]  in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_wb;
  logic              out_branch;
  logic              out_memread;
  logic              out_memwrite;
  logic              out_zero;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_wdata;
  logic [DATA_W-1:0] out_btarget;
  logic [REG_W-1:0]  out_rd;

  logic [1:0]        occupancy;

  // The pipeline register itself
  modport slave (
    input  in_valid, in_wb, in_m, in_zero, in_alu, in_wdata, in_btarget, in_rd,
    input  out_ready,
    output in_ready,
    output out_valid, out_wb, out_branch, out_memread, out_memwrite, out_zero,
    output out_alu, out_wdata, out_btarget, out_rd, occupancy
  );

  // Whatever surrounds it: EX producer and MEM consumer
  modport master (
    output in_valid, in_wb, in_m, in_zero, in_alu, in_wdata, in_btarget, in_rd,
    output out_ready,
    input  in_ready,
    input  out_valid, out_wb, out_branch, out_memread, out_memwrite, out_zero,
    input  out_alu, out_wdata, out_btarget, out_rd, occupancy
  );
endinterface

// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer. The main entry
// drives MEM; the skid entry catches the one extra entry that can arrive
// while MEM stalls, so in_ready can be a pure register output.
module exmem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  exmem_skid_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]        wb;
    logic [2:0]        m;      // [2] branch, [1] mem-read, [0] mem-write
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] btarget;
    logic [REG_W-1:0]  rd;
  } entry_t;

  state_t state_reg, state_next;
  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  entry_t in_entry;
  logic   in_ready_reg;
  logic   out_valid;
  logic   in_xfer;
  logic   out_xfer;

  assign in_entry = '{wb: bus.in_wb, m: bus.in_m, zero: bus.in_zero,
                      alu: bus.in_alu, wdata: bus.in_wdata,
                      btarget: bus.in_btarget, rd: bus.in_rd};

  assign out_valid = (state_reg != EMPTY);
  assign in_xfer   = bus.in_valid & in_ready_reg;
  assign out_xfer  = out_valid & bus.out_ready;

  // Next state and next entry contents; flush wins over any transfer
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          main_next  = in_entry;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_next = in_entry;
        end else if (in_xfer) begin
          skid_next  = in_entry;
          state_next = TWO;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_next  = skid_reg;
          skid_next  = '0;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      // Squash: drop any incoming entry, kill controls, keep data fields
      state_next   = EMPTY;
      main_next    = main_reg;
      skid_next    = skid_reg;
      main_next.wb = '0;
      main_next.m  = '0;
      skid_next.wb = '0;
      skid_next.m  = '0;
    end
  end

  // State, entries and registered in_ready; reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != TWO);
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid;
  assign bus.occupancy    = state_reg;
  // Controls become a bubble when nothing is presented
  assign bus.out_wb       = out_valid ? main_reg.wb   : 2'b00;
  assign bus.out_branch   = out_valid & main_reg.m[2];
  assign bus.out_memread  = out_valid & main_reg.m[1];
  assign bus.out_memwrite = out_valid & main_reg.m[0];
  assign bus.out_zero     = main_reg.zero;
  assign bus.out_alu      = main_reg.alu;
  assign bus.out_wdata    = main_reg.wdata;
  assign bus.out_btarget  = main_reg.btarget;
  assign bus.out_rd       = main_reg.rd;

endmodule

// File: tb/tb_exmem_skid_reg.sv
// Directed bench for exmem_skid_reg: a vector table for streaming,
// backpressure, bubble, decode and flush, plus hand sequences for reset.
module tb_exmem_skid_reg;

  logic clk;
  logic rst_n;
  logic flush;

  exmem_skid_if #(.DATA_W(32), .REG_W(5)) bus ();

  exmem_skid_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        iv;
    logic [31:0] alu;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic        z;
    logic [4:0]  rd;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_alu;
    logic [1:0]  e_occ;
    logic        e_irdy;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic        e_z;
    logic [4:0]  e_rd;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic [31:0] alu, logic [2:0] m, logic [1:0] wb,
                              logic z, logic [4:0] rd, logic ordy, logic fl,
                              logic e_ov, logic [31:0] e_alu, logic [1:0] e_occ,
                              logic e_irdy, logic [1:0] e_wb, logic [2:0] e_m,
                              logic e_z, logic [4:0] e_rd);
    vec_t v;
    v.iv = iv; v.alu = alu; v.m = m; v.wb = wb; v.z = z; v.rd = rd;
    v.ordy = ordy; v.fl = fl; v.e_ov = e_ov; v.e_alu = e_alu; v.e_occ = e_occ;
    v.e_irdy = e_irdy; v.e_wb = e_wb; v.e_m = e_m; v.e_z = e_z; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  // Store data and branch target are derived from the ALU value
  task automatic drive(logic iv, logic [31:0] alu, logic [2:0] m, logic [1:0] wb,
                       logic z, logic [4:0] rd, logic ordy, logic fl);
    bus.in_valid   = iv;
    bus.in_alu     = alu;
    bus.in_wdata   = alu ^ 32'hFFFF_0000;
    bus.in_btarget = alu + 32'd100;
    bus.in_m       = m;
    bus.in_wb      = wb;
    bus.in_zero    = z;
    bus.in_rd      = rd;
    bus.out_ready  = ordy;
    flush          = fl;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            iv alu       m     wb  z  rd  ordy fl | ov alu     occ irdy wb m    z  rd
    // streaming
    vecs[0]  = mk(1, 32'h1,  3'd0, 2'd0, 0, 5'd0,  1, 0,  1, 32'h1,  2'd1, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[1]  = mk(1, 32'h2,  3'd0, 2'd0, 0, 5'd0,  1, 0,  1, 32'h2,  2'd1, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[2]  = mk(1, 32'h3,  3'd0, 2'd0, 0, 5'd0,  1, 0,  1, 32'h3,  2'd1, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[3]  = mk(1, 32'h4,  3'd0, 2'd0, 0, 5'd0,  1, 0,  1, 32'h4,  2'd1, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[4]  = mk(0, 32'h0,  3'd0, 2'd0, 0, 5'd0,  1, 0,  0, 32'h4,  2'd0, 1, 2'd0, 3'd0, 0, 5'd0);
    // backpressure: 0xC offered while full must be ignored
    vecs[5]  = mk(1, 32'hA,  3'd0, 2'd0, 0, 5'd0,  0, 0,  1, 32'hA,  2'd1, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[6]  = mk(1, 32'hB,  3'd0, 2'd0, 0, 5'd0,  0, 0,  1, 32'hA,  2'd2, 0, 2'd0, 3'd0, 0, 5'd0);
    vecs[7]  = mk(1, 32'hC,  3'd0, 2'd0, 0, 5'd0,  0, 0,  1, 32'hA,  2'd2, 0, 2'd0, 3'd0, 0, 5'd0);
    vecs[8]  = mk(0, 32'h0,  3'd0, 2'd0, 0, 5'd0,  1, 0,  1, 32'hB,  2'd1, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[9]  = mk(0, 32'h0,  3'd0, 2'd0, 0, 5'd0,  1, 0,  0, 32'hB,  2'd0, 1, 2'd0, 3'd0, 0, 5'd0);
    // bubble
    vecs[10] = mk(1, 32'h55, 3'd2, 2'd3, 0, 5'd0,  0, 0,  1, 32'h55, 2'd1, 1, 2'd3, 3'd2, 0, 5'd0);
    vecs[11] = mk(0, 32'h0,  3'd0, 2'd0, 0, 5'd0,  1, 0,  0, 32'h55, 2'd0, 1, 2'd0, 3'd0, 0, 5'd0);
    // decode
    vecs[12] = mk(1, 32'h66, 3'd5, 2'd1, 1, 5'd17, 0, 0,  1, 32'h66, 2'd1, 1, 2'd1, 3'd5, 1, 5'd17);
    vecs[13] = mk(0, 32'h0,  3'd0, 2'd0, 0, 5'd0,  1, 0,  0, 32'h66, 2'd0, 1, 2'd0, 3'd0, 1, 5'd17);
    // flush from TWO with input offered
    vecs[14] = mk(1, 32'h71, 3'd0, 2'd0, 0, 5'd0,  1, 0,  1, 32'h71, 2'd1, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[15] = mk(1, 32'h72, 3'd3, 2'd2, 0, 5'd0,  0, 0,  1, 32'h71, 2'd2, 0, 2'd0, 3'd0, 0, 5'd0);
    vecs[16] = mk(1, 32'hEE, 3'd7, 2'd3, 0, 5'd0,  0, 1,  0, 32'h71, 2'd0, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[17] = mk(0, 32'h0,  3'd0, 2'd0, 0, 5'd0,  1, 0,  0, 32'h71, 2'd0, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[18] = mk(1, 32'h80, 3'd0, 2'd0, 0, 5'd0,  1, 0,  1, 32'h80, 2'd1, 1, 2'd0, 3'd0, 0, 5'd0);
    // flush with simultaneous in and out transfer: 0x90 discarded
    vecs[19] = mk(1, 32'h90, 3'd7, 2'd3, 0, 5'd0,  1, 1,  0, 32'h80, 2'd0, 1, 2'd0, 3'd0, 0, 5'd0);
    vecs[20] = mk(0, 32'h0,  3'd0, 2'd0, 0, 5'd0,  1, 0,  0, 32'h80, 2'd0, 1, 2'd0, 3'd0, 0, 5'd0);

    // Power-on reset
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset.out_valid", 32'(bus.out_valid), 0);
    chk("reset.in_ready",  32'(bus.in_ready), 0);
    chk("reset.occupancy", 32'(bus.occupancy), 0);
    chk("reset.out_alu",   bus.out_alu, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release.in_ready", 32'(bus.in_ready), 1);
    $display("reset released: in_ready=%0b occupancy=%0d", bus.in_ready, bus.occupancy);

    // Table: drive at a falling edge, sample at the next falling edge
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].alu, vecs[i].m, vecs[i].wb, vecs[i].z,
            vecs[i].rd, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d.out_alu", i), bus.out_alu, vecs[i].e_alu);
      chk($sformatf("v%0d.out_wdata", i), bus.out_wdata, vecs[i].e_alu ^ 32'hFFFF_0000);
      chk($sformatf("v%0d.out_btarget", i), bus.out_btarget, vecs[i].e_alu + 32'd100);
      chk($sformatf("v%0d.occupancy", i), 32'(bus.occupancy), 32'(vecs[i].e_occ));
      chk($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_irdy));
      chk($sformatf("v%0d.out_wb", i), 32'(bus.out_wb), 32'(vecs[i].e_wb));
      chk($sformatf("v%0d.out_m", i),
          32'({bus.out_branch, bus.out_memread, bus.out_memwrite}), 32'(vecs[i].e_m));
      chk($sformatf("v%0d.out_zero", i), 32'(bus.out_zero), 32'(vecs[i].e_z));
      chk($sformatf("v%0d.out_rd", i), 32'(bus.out_rd), 32'(vecs[i].e_rd));
      $display("vec %0d: iv=%0b alu=%0h ordy=%0b fl=%0b -> ov=%0b alu=%0h occ=%0d irdy=%0b",
               i, vecs[i].iv, vecs[i].alu, vecs[i].ordy, vecs[i].fl,
               bus.out_valid, bus.out_alu, bus.occupancy, bus.in_ready);
    end

    // Asynchronous reset while full, between clock edges
    drive(1, 32'hD1, 3'd2, 2'd1, 0, 5'd3, 0, 0);
    @(negedge clk);
    drive(1, 32'hD2, 3'd1, 2'd2, 0, 5'd4, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("async.pre_occupancy", 32'(bus.occupancy), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.out_valid", 32'(bus.out_valid), 0);
    chk("async.in_ready",  32'(bus.in_ready), 0);
    chk("async.occupancy", 32'(bus.occupancy), 0);
    chk("async.out_alu",   bus.out_alu, 0);
    chk("async.out_rd",    32'(bus.out_rd), 0);
    $display("async reset: ov=%0b irdy=%0b occ=%0d", bus.out_valid, bus.in_ready, bus.occupancy);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("async.ready_before_edge", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("async.ready_after_edge", 32'(bus.in_ready), 1);
    chk("async.occ_after_edge",   32'(bus.occupancy), 0);
    chk("async.ov_after_edge",    32'(bus.out_valid), 0);
    $display("async release: irdy=%0b occ=%0d", bus.in_ready, bus.occupancy);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exmem_skid_reg.md
EXMEM_SKID_REG -- requirements
Module: exmem_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result, store data and branch target.
REQ-002 Parameter REG_W, default 5, width of destination register index.
REQ-003 clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous squash of all held entries.
REQ-006 in_valid  input  1  upstream (EX) entry present.
REQ-007 in_ready  output  1  block accepts an entry this cycle.
REQ-008 in_wb  input  2  write-back control field.
REQ-009 in_m  input  3  memory control field: [2] branch, [1] mem-read, [0] mem-write.
REQ-010 in_zero  input  1  ALU zero flag.
REQ-011 in_alu, in_wdata, in_btarget  input  DATA_W each  ALU result, store data, branch target.
REQ-012 in_rd  input  REG_W  destination register index.
REQ-013 out_valid  output  1  entry presented to MEM.
REQ-014 out_ready  input  1  MEM consumes the presented entry this cycle.
REQ-015 out_wb (2), out_branch, out_memread, out_memwrite, out_zero (1 each)  outputs  control and flag of presented entry.
REQ-016 out_alu, out_wdata, out_btarget (DATA_W), out_rd (REG_W)  outputs  data of presented entry.
REQ-017 occupancy  output  2  entries held: 0, 1 or 2.

Function
REQ-018 Storage SHALL be two entries: main (drives outputs) and skid; state EMPTY (0), ONE (main only), TWO (main and skid).
REQ-019 Transfer in SHALL occur when in_valid and in_ready are both high at a rising edge; transfer out when out_valid and out_ready are both high.
REQ-020 in_ready SHALL be a registered signal, high in EMPTY and ONE, low in TWO.
REQ-021 EMPTY: transfer in -> main loaded, ONE; otherwise stay.
REQ-022 ONE: in and out together -> main reloaded from input, stay ONE; in only -> skid loaded, TWO; out only -> EMPTY; neither -> hold.
REQ-023 TWO: out -> main loaded from skid, skid cleared, ONE; otherwise hold all contents.
REQ-024 out_valid SHALL be high exactly in ONE and TWO.
REQ-025 Latency SHALL be one cycle from input transfer into EMPTY to out_valid high; throughput one entry per cycle while out_ready stays high.
REQ-026 Entries SHALL leave in acceptance order; none SHALL be lost or duplicated.
REQ-027 When out_valid is low, out_wb, out_branch, out_memread and out_memwrite SHALL be forced to 0 combinationally (bubble); data outputs keep the last main contents.
REQ-028 Branch, mem-read and mem-write SHALL come from in_m bits 2, 1 and 0 respectively.
REQ-029 flush high at an edge SHALL put the block in EMPTY and zero the control fields of both entries; data fields keep their values.
REQ-030 flush SHALL override a simultaneous input transfer: the entry is discarded.
REQ-031 flush SHALL override a simultaneous output transfer: the transfer still counts as completed for MEM.
REQ-032 in_ready SHALL be high the cycle after a flush.
REQ-033 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE and TWO.

Reset
REQ-034 rst_n low SHALL force at once, independent of clk: state EMPTY, all entry fields 0, out_valid 0, in_ready 0, occupancy 0.
REQ-035 in_ready SHALL rise at the first rising edge after rst_n deasserts.
REQ-036 Reset asserted mid-transfer SHALL discard all held entries with no partial update.

Verification
REQ-037 Streaming: out_ready=1; 4 entries in_alu=1,2,3,4 on back-to-back cycles -> out_alu 1,2,3,4 on the following 4 cycles, out_valid high for those cycles, occupancy 1.
REQ-038 Backpressure: out_ready=0; accept in_alu=0xA then 0xB -> occupancy 2, in_ready 0, out_alu=0xA held; raise out_ready -> 0xA then 0xB delivered, in_ready back to 1.
REQ-039 Bubble: in_m=3'b010, in_wb=2'b11 accepted and consumed, then in_valid=0 -> out_memread=0, out_wb=0, out_alu keeps the last value.
REQ-040 Flush: occupancy 2, flush=1 with in_valid=1 -> next cycle occupancy 0, out_valid 0, all control outputs 0, in_ready 1; the flushed input never appears.
REQ-041 Async reset: rst_n pulled low between edges while occupancy 2 -> out_valid, in_ready and occupancy read 0 before the next edge; in_ready rises at the first edge after release.
REQ-042 Decode: in_m=3'b101, in_zero=1, in_rd=5'd17 -> out_branch=1, out_memread=0, out_memwrite=1, out_zero=1, out_rd=17 one cycle later.
